// File: rtl/ram_pkg.sv
// Shared constants and types for the memories exercise (ROM, sync RAM, async RAM).
package ram_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage

// File: rtl/ram_word.sv
// One storage word: a DATA_W register with asynchronous clear and a write enable.
module ram_word #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear takes priority, so an edge that lands while rst_n is low never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_async.sv
// 256x8 single-port RAM: clocked write, combinational read, async active-low clear.
module ram_async
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] direccion,
    input  logic [DATA_W-1:0] Dato_E,
    input  logic              EN,
    output logic [DATA_W-1:0] dato_s
);

    logic [DATA_W-1:0] words [DEPTH];

    // One register per address; only the addressed word sees its write enable.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        ram_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (EN && (direccion == ADDR_W'(i))),
            .d     (Dato_E),
            .q     (words[i])
        );
    end

    // DEPTH covers the whole address space, so every index selects a real word.
    assign dato_s = words[direccion];

endmodule

// File: tb/tb_ram_async.sv
// Self-checking bench for ram_async: vector table plus hand sequences, checked through a scoreboard queue.
module tb_ram_async;
    import ram_pkg::*;

    logic      clk;
    logic      rst_n;
    ram_addr_t direccion;
    ram_word_t Dato_E;
    logic      EN;
    ram_word_t dato_s;

    int checks = 0;
    int errors = 0;
    ram_word_t expected_q[$];

    typedef struct {
        ram_addr_t addr;
        ram_word_t data;
        logic      en;
        ram_word_t exp_val;
        string     name;
    } vec_t;

    vec_t vecs[15];

    ram_async #(
        .ADDR_W (RAM_ADDR_W),
        .DATA_W (RAM_DATA_W),
        .DEPTH  (RAM_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .direccion (direccion),
        .Dato_E    (Dato_E),
        .EN        (EN),
        .dato_s    (dato_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs away from the rising edge and record what dato_s must show afterwards.
    task automatic applyStimulus(input ram_addr_t a, input ram_word_t d, input logic e,
                                 input ram_word_t exp_val);
        direccion = a;
        Dato_E    = d;
        EN        = e;
        expected_q.push_back(exp_val);
    endtask

    task automatic checkOutput(input string name);
        ram_word_t exp_val;
        checks++;
        if (expected_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got 0x%02h", name, dato_s);
        end else begin
            exp_val = expected_q.pop_front();
            if (dato_s !== exp_val) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, dato_s, exp_val);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{8'd0,   8'h00, 1'b0, 8'h00, "reset_read_0"};
        vecs[1]  = '{8'd9,   8'h00, 1'b0, 8'h00, "reset_read_9"};
        vecs[2]  = '{8'd5,   8'h00, 1'b0, 8'h00, "reset_read_5"};
        vecs[3]  = '{8'd255, 8'h00, 1'b0, 8'h00, "reset_read_255"};
        vecs[4]  = '{8'd9,   8'd120, 1'b1, 8'd120, "write_9"};
        vecs[5]  = '{8'd9,   8'h00, 1'b0, 8'd120, "hold_9"};
        vecs[6]  = '{8'd5,   8'h00, 1'b0, 8'h00, "isolate_5"};
        vecs[7]  = '{8'd255, 8'hAA, 1'b1, 8'hAA, "write_255"};
        vecs[8]  = '{8'd0,   8'h55, 1'b1, 8'h55, "write_0"};
        vecs[9]  = '{8'd255, 8'h00, 1'b0, 8'hAA, "read_255"};
        vecs[10] = '{8'd0,   8'h00, 1'b0, 8'h55, "read_0"};
        vecs[11] = '{8'd9,   8'h00, 1'b0, 8'd120, "read_9"};
        vecs[12] = '{8'd9,   8'hFF, 1'b0, 8'd120, "en_gate_1"};
        vecs[13] = '{8'd9,   8'hFF, 1'b0, 8'd120, "en_gate_2"};
        vecs[14] = '{8'd9,   8'hFF, 1'b0, 8'd120, "en_gate_3"};

        rst_n     = 1'b0;
        direccion = '0;
        Dato_E    = '0;
        EN        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("reset_active");
        @(negedge clk);
        rst_n = 1'b1;

        // Each vector is applied on a falling edge and checked just after the next rising edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].en, vecs[i].exp_val);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name);
        end

        // Read-during-write: old word before the edge, new word right after it.
        @(negedge clk);
        applyStimulus(8'd7, 8'h3C, 1'b1, 8'h00);
        #1;
        checkOutput("rdw_before");
        @(posedge clk);
        #1;
        expected_q.push_back(8'h3C);
        checkOutput("rdw_after");
        @(negedge clk);
        applyStimulus(8'd8, 8'h00, 1'b0, 8'h00);
        #1;
        checkOutput("rdw_neighbour_8");
        applyStimulus(8'd6, 8'h00, 1'b0, 8'h00);
        #1;
        checkOutput("rdw_neighbour_6");

        // Asynchronous clear between edges, then a write edge while rst_n is low.
        applyStimulus(8'd9, 8'h00, 1'b0, 8'd120);
        #1;
        checkOutput("pre_reset_9");
        rst_n = 1'b0;
        #1;
        expected_q.push_back(8'h00);
        checkOutput("reset_async_9");
        applyStimulus(8'd9, 8'h11, 1'b1, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("reset_write_blocked");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd9, 8'h00, 1'b0, 8'h00);
        #1;
        checkOutput("write_discarded_9");

        for (int a = 0; a < RAM_DEPTH; a++) begin
            applyStimulus(ram_addr_t'(a), 8'h00, 1'b0, 8'h00);
            #1;
            checkOutput($sformatf("sweep_%0d", a));
        end

        // First write after release lands on the first rising edge.
        @(negedge clk);
        applyStimulus(8'd3, 8'h77, 1'b1, 8'h77);
        @(posedge clk);
        #1;
        checkOutput("post_release_write");
        @(negedge clk);
        applyStimulus(8'd4, 8'h00, 1'b0, 8'h00);
        #1;
        checkOutput("post_release_neighbour");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_async.md
# ram_async

256×8 single-port RAM with a clocked write and an asynchronous (combinational) read. It is the general-purpose data store of the memories exercise, alongside the ROM and synchronous-RAM blocks. It presents one shared address bus, an 8-bit write-data bus, a write enable and an 8-bit read-data bus. All words are cleared by an asynchronous active-low reset.

## Interface
Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, word width in bits.
- DEPTH, 2**ADDR_W (256), number of words. Fixed to a full address space, so there are no out-of-range addresses.

Ports:
- clk  input  1  write clock; rising edge active.
- rst_n  input  1  reset, asynchronous, active-low. One clock; the polarity and synchronicity of rst_n are fixed.
- direccion  input  ADDR_W  address for both read and write.
- Dato_E  input  DATA_W  write data.
- EN  input  1  write enable: 1 = write, 0 = read only.
- dato_s  output  DATA_W  read data. Always reflects mem[direccion].

## Operation
- Storage: array mem[0..DEPTH-1] of DATA_W-bit words.
- Reset:
  - rst_n low clears every word to 0 immediately, without waiting for clk.
  - All words hold 0 while rst_n stays low.
  - dato_s therefore reads 0 during reset.
- Write: on rising clk with rst_n=1 and EN=1, mem[direccion] <= Dato_E. Only that one word changes.
- EN=0: no word changes, regardless of Dato_E.
- Read:
  - dato_s = mem[direccion], purely combinational, independent of EN and clk.
  - No output register; dato_s is never X after reset.
- Read-during-write at the same address:
  - Before the clk edge, dato_s shows the old word.
  - After the edge, dato_s shows the new word (combinational path from the updated array).
- Write to address A leaves every other address unchanged.

## Timing
- Read latency: combinational. dato_s settles within one propagation delay of a direccion change or of the write edge.
- Write latency: 1 clk edge. Data is visible on dato_s in the same cycle, immediately after the edge.
- Reset asserted mid-operation:
  - A write edge coinciding with rst_n low is discarded.
  - Contents are lost (all words become 0).
- Reset release: the first write can occur on the first rising clk after rst_n returns high.
- Address/data/EN requirements:
  - They must be stable around the clk rising edge (setup/hold).
  - They may change arbitrarily between edges without corrupting memory.
- Address wrap-around: not applicable. All 8-bit values are valid: 0 and 255 are ordinary words.

## Structure
- Shared package ram_pkg:
  - Constants RAM_ADDR_W=8, RAM_DATA_W=8, RAM_DEPTH=256.
  - Typedefs ram_addr_t and ram_word_t.
  - The ROM and synchronous-RAM blocks reuse these.
- One natural sub-module: ram_word, a single DATA_W register with async clear and a write-enable.
  - Instantiate DEPTH times.
  - Each instance's write-enable = EN & (direccion == index).
  - Read side is a DEPTH:1 mux in ram_async.
- Alternatively, a single array implementation without sub-modules is acceptable; the behaviour is identical.

## Test plan
- Reset: rst_n=0 then 1, direccion=0, EN=0 -> dato_s=0. Step direccion 9, then 5, then 255 -> dato_s=0 at each.
- Write/read-back: direccion=9, Dato_E=120, EN=1, one clk edge -> dato_s=120 right after the edge. Then EN=0, Dato_E=0 -> dato_s stays 120.
- Isolation:
  - After the 120 write to address 9, direccion=5 -> dato_s=0.
  - Write 0xAA to 255, then 0x55 to 0 -> reads give 255=0xAA, 0=0x55, 9=120.
- EN gating: direccion=9, EN=0, Dato_E=0xFF, several clk edges -> dato_s remains 120.
- Read-during-write: direccion=7 (holding 0), EN=1, Dato_E=0x3C -> dato_s=0 before the edge, 0x3C after.
- Reset mid-operation:
  - Set rst_n=0 between clk edges -> dato_s at 9 drops to 0 without a clk edge.
  - Set EN=1 and Dato_E=0x11 at a clk edge while rst_n=0 -> still 0 after release.
  - Full sweep of addresses 0..255 after release -> all 0.
